regfile_mp: RTL
===============

# regfile_mp

Parametrised successor to the 8x16 single-read register file for the Simple RISC Machine datapath. It provides one synchronous write port, two combinational read ports and an asynchronous active-low reset. Each register carries a written-valid bit and a pending (scoreboard) bit so the controller can detect reads of never-written registers and in-flight producers. It sits between the instruction decoder/controller and the ALU operand latches.

## Interface
- WIDTH, 16, data width in bits (>=1)
- DEPTH, 8, number of registers (>=2, need not be a power of two)
- AW (localparam), $clog2(DEPTH), index width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- data_in  in  WIDTH  write data
- writenum  in  AW  write index
- write  in  1  write enable, sampled on rising clk
- readnum_a, readnum_b  in  AW  read indices (combinational)
- data_out_a, data_out_b  out  WIDTH  read data
- valid_a, valid_b  out  1  addressed register has been written since reset
- rsv  in  1  reserve enable: mark rsvnum as having an outstanding producer
- rsvnum  in  AW  reserve index
- busy_a, busy_b  out  1  addressed register is pending
- pending  out  DEPTH  per-register pending bits, bit i = register i

## Operation
- Storage: DEPTH x WIDTH flops, valid[DEPTH], pending[DEPTH].
- Write: on rising clk with write=1 and writenum<DEPTH: reg[writenum]<=data_in, valid[writenum]<=1, pending[writenum]<=0.
- Reserve: on rising clk with rsv=1 and rsvnum<DEPTH: pending[rsvnum]<=1.
- Simultaneous write and reserve to the same index: data and valid update, pending ends 1 (reserve wins; new producer issued).
- Write and reserve to different indices: both take effect in the same edge.
- Reads: data_out_x = reg[readnum_x], valid_x = valid[readnum_x], busy_x = pending[readnum_x]; purely combinational, independent of clk.
- Both read ports may address the same register; outputs are identical.
- Out-of-range index (>=DEPTH, only possible when DEPTH not a power of two): write/reserve ignored; read returns data 0, valid 0, busy 0.
- Unwritten register reads return 0 with valid=0 (never X).

## Timing
- Reset (reset_n=0, asynchronous, no clk needed): all reg=0, valid=0, pending=0; therefore data_out_a/b=0, valid_a/b=0, busy_a/b=0, pending=0 immediately.
- Reset deasserted mid-operation: state held at reset values until the first rising clk with reset_n=1; a write coincident with reset assertion is lost.
- Write latency: new value visible on read ports after the write edge (same cycle, after clk-to-q); never before the edge unless bypass is compiled in.
- Reserve latency: busy visible after the reserve edge.
- Read-port change mid-cycle: outputs follow readnum within the combinational delay; no clk dependency.
- No backpressure; every write/reserve presented at an edge is accepted.

## Configuration
- REGFILE_MP_BYPASS_EN defined: write-through forwarding. When write=1 and readnum_x==writenum (in range), data_out_x=data_in, valid_x=1 and busy_x=0 combinationally in the cycle before the edge (busy_x=1 if rsv=1 and rsvnum==writenum). Storage update at the edge is unchanged.
- Not defined: read ports reflect stored state only; a value written at edge N is readable only after edge N.

## Test plan
- Reset: after writing 16'h00FF to R3, pulse reset_n low between edges -> data_out_a=0, valid_a=0, pending=8'h00 before next clk.
- Dual read: write R0=8, R7=16'hFFFF -> readnum_a=0, readnum_b=7 gives 8 and 16'hFFFF, both valid=1; write=0 with data_in=16 leaves R0=8.
- Unwritten read: readnum_a=1 after reset with no writes to R1 -> data_out_a=0, valid_a=0, never X.
- Scoreboard: rsv R2 -> busy=1, pending=8'h04; write R2=1659 -> busy=0, data=1659; simultaneous write R2=5 and rsv R2 -> data=5, busy=1.
- Async read: change readnum_a from 3 to 2 at 7 ps into a cycle -> output switches within the same cycle without clk edge.
- Bypass/non-power-of-two: with REGFILE_MP_BYPASS_EN, write R4=320 with readnum_a=4 -> data_out_a=320 before edge; without, old value until edge; DEPTH=6 write to index 7 -> ignored, read index 7 returns 0/valid 0.

Source files
------------

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : parametrised multi-port register file with scoreboard bits
//
// One synchronous write port, two combinational read ports. Every register
// carries a valid bit (written since reset) and a pending bit (an in-flight
// producer has been reserved and has not yet written back).
//
// Parameters
//   WIDTH      data width in bits (>=1)
//   DEPTH      number of registers (>=2, need not be a power of two)
//
// Ports
//   clk                      rising-edge clock
//   reset_n                  asynchronous active-low reset
//   data_in, writenum, write write data / index / enable
//   rsv, rsvnum              reserve enable / index (sets pending)
//   readnum_a, readnum_b     read indices (combinational)
//   data_out_a, data_out_b   read data
//   valid_a, valid_b         addressed register written since reset
//   busy_a, busy_b           addressed register pending
//   pending                  per-register pending bits, bit i = register i
//
// Optional feature
//   REGFILE_MP_BYPASS_EN     when defined, a write in progress is forwarded
//                            combinationally to any read port addressing the
//                            same register, ahead of the clock edge.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(DEPTH)-1:0] writenum,
    input  logic                     write,
    input  logic [$clog2(DEPTH)-1:0] readnum_a,
    input  logic [$clog2(DEPTH)-1:0] readnum_b,
    output logic [WIDTH-1:0]         data_out_a,
    output logic [WIDTH-1:0]         data_out_b,
    output logic                     valid_a,
    output logic                     valid_b,
    input  logic                     rsv,
    input  logic [$clog2(DEPTH)-1:0] rsvnum,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [DEPTH-1:0]         pending
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] data_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] pending_reg;

    // One-hot decode of the write and reserve indices. Indices at or above
    // DEPTH match no register, so out-of-range requests fall away here.
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] rsv_hit;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] pending_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_hit[gi]       = write && (writenum == AW'(gi));
            assign rsv_hit[gi]      = rsv && (rsvnum == AW'(gi));
            assign valid_next[gi]   = valid_reg[gi] | wr_hit[gi];
            // A reserve on the same edge as the write-back means a new
            // producer was issued, so the reserve takes priority.
            assign pending_next[gi] = rsv_hit[gi] | (pending_reg[gi] & ~wr_hit[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg   <= '0;
            pending_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg   <= valid_next;
            pending_reg <= pending_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    data_reg[i] <= data_in;
                end
            end
        end
    end

    // Read lookup packs {data, valid, pending}. Scanning the populated
    // entries (rather than indexing the array) makes an out-of-range index
    // return all zeros without ever touching a nonexistent entry.
    function automatic logic [WIDTH+1:0] lookup(input logic [AW-1:0] idx);
        logic [WIDTH+1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == AW'(i)) begin
                r = {data_reg[i], valid_reg[i], pending_reg[i]};
            end
        end
        return r;
    endfunction

    logic [WIDTH+1:0] rd_a;
    logic [WIDTH+1:0] rd_b;

`ifdef REGFILE_MP_BYPASS_EN
    // write_live: an in-range write is being presented this cycle.
    // rsv_same:   the same register is also being re-reserved, so the
    //             forwarded value still belongs to a pending register.
    logic write_live;
    logic rsv_same;
    assign write_live = |wr_hit;
    assign rsv_same   = |(wr_hit & rsv_hit);

    always_comb begin
        rd_a = lookup(readnum_a);
        rd_b = lookup(readnum_b);
        if (write_live && (readnum_a == writenum)) begin
            rd_a = {data_in, 1'b1, rsv_same};
        end
        if (write_live && (readnum_b == writenum)) begin
            rd_b = {data_in, 1'b1, rsv_same};
        end
    end
`else
    always_comb begin
        rd_a = lookup(readnum_a);
        rd_b = lookup(readnum_b);
    end
`endif

    assign data_out_a = rd_a[WIDTH+1:2];
    assign valid_a    = rd_a[1];
    assign busy_a     = rd_a[0];
    assign data_out_b = rd_b[WIDTH+1:2];
    assign valid_b    = rd_b[1];
    assign busy_b     = rd_b[0];
    assign pending    = pending_reg;

endmodule
